// File: rtl/wb_sram_ctrl_if.sv
// wb_sram_ctrl_if -- Wishbone classic bus bundle between a 32-bit-address /
// 16-bit-data master and the SRAM controller.
//   adr   : byte address (master -> slave)
//   dat_w : write data (master -> slave)
//   sel   : byte lanes, [1]=bits 15:8, [0]=bits 7:0 (master -> slave)
//   we, cyc, stb : classic cycle controls (master -> slave)
//   dat_r : read data (slave -> master)
//   ack   : transfer acknowledge (slave -> master)
interface wb_sram_ctrl_if;
  logic [31:0] adr;
  logic [15:0] dat_w;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [15:0] dat_r;
  logic        ack;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl -- Wishbone classic slave driving an asynchronous 16-bit SRAM.
// One access per Wishbone cycle: a read holds ce_n/oe_n low for RD_WAIT
// cycles, a write pulses we_n for WR_WAIT cycles followed by one hold cycle.
// Every output comes straight from a flop.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wb             : Wishbone slave bundle (wb_sram_ctrl_if.slave)
//   sram_adr_o     : SRAM word address
//   sram_dq_o/_i   : SRAM data out / in, sram_dq_oe_o = pad output enable
//   sram_*_n_o     : active-low chip/output/write/upper/lower byte strobes
//   busy_o         : high whenever the controller is not idle
//
// state | meaning
// IDLE  | waiting for cyc&stb, request fields latched on acceptance
// READ  | ce_n/oe_n low, data sampled when the counter reaches zero
// WRITE | ce_n/we_n low, data driven onto the pads
// HOLD  | we_n released, address/data still driven for hold time
// ACK   | one-cycle acknowledge, all strobes high
module wb_sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_sram_ctrl_if.slave     wb,
  output logic [ADDR_W-1:0] sram_adr_o,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_ub_n_o,
  output logic              sram_lb_n_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [15:0]       wdat_q, wdat_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;

  // Address bits outside the word range are decoded externally.
  logic unused_adr;
  assign unused_adr = ^{wb.adr[31:ADDR_W+1], wb.adr[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wb.cyc && wb.stb) begin
          adr_d  = wb.adr[ADDR_W:1];
          wdat_d = wb.dat_w;
          sel_d  = wb.sel;
          if (wb.we) begin
            state_d = WRITE;
            cnt_d   = WR_CNT;
          end else begin
            state_d = READ;
            cnt_d   = RD_CNT;
          end
        end
      end
      READ: begin
        // A dropped cyc lets the SRAM cycle finish but suppresses the ack.
        abort_d = abort_q | ~wb.cyc;
        if (cnt_q == 4'd0) begin
          rdat_d  = sram_dq_i;
          state_d = abort_d ? IDLE : ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        abort_d = abort_q | ~wb.cyc;
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        abort_d = abort_q | ~wb.cyc;
        state_d = abort_d ? IDLE : ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ack_d   = 1'b0;
    busy_d  = (state_d != IDLE);

    case (state_d)
      READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = ~sel_d[1];
        lb_n_d = ~sel_d[0];
      end
      WRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ~sel_d[1];
        lb_n_d  = ~sel_d[0];
      end
      HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ~sel_d[1];
        lb_n_d  = ~sel_d[0];
      end
      ACK: begin
        ack_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      abort_q <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= 16'h0000;
      sel_q   <= 2'b00;
      rdat_q  <= 16'h0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  assign wb.dat_r     = rdat_q;
  assign wb.ack       = ack_q;
  assign sram_adr_o   = adr_q;
  assign sram_dq_o    = wdat_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_ub_n_o  = ub_n_q;
  assign sram_lb_n_o  = lb_n_q;
  assign busy_o       = busy_q;

endmodule
